// File: rtl/common_types_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and the native word.
package common_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } arb_state_t;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data access.
// Data requests win over fetches; a load/store returns ihit and dhit together.
module memory_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  iREN,
  input  logic [ADDR_W-1:0]     iaddr,
  output logic                  ihit,
  output logic [DATA_W-1:0]     iload,
  input  logic                  dREN,
  input  logic                  dWEN,
  input  logic [ADDR_W-1:0]     daddr,
  input  logic [DATA_W-1:0]     dstore,
  input  logic [DATA_W/8-1:0]   dstrobe,
  output logic                  dhit,
  output logic [DATA_W-1:0]     dload,
  output logic                  ram_ren,
  output logic                  ram_wen,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_strobe,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic                  ram_ready
);
  import common_types_pkg::*;

  arb_state_t                state_reg, state_next;
  logic [ADDR_W-1:0]         addr_reg, addr_next;
  logic [DATA_W-1:0]         wdata_reg, wdata_next;
  logic [DATA_W/8-1:0]       strobe_reg, strobe_next;
  logic                      write_reg, write_next;
  logic                      d_done_reg, d_done_next;
  logic [DATA_W-1:0]         dload_reg, dload_next;

  logic d_req;
  logic fetch_ok;

  assign d_req    = dREN | dWEN;
  assign fetch_ok = iREN && (iaddr == addr_reg);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      strobe_reg <= '0;
      write_reg  <= 1'b0;
      d_done_reg <= 1'b0;
      dload_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      strobe_reg <= strobe_next;
      write_reg  <= write_next;
      d_done_reg <= d_done_next;
      dload_reg  <= dload_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    strobe_next = strobe_reg;
    write_next  = write_reg;
    d_done_next = d_done_reg;
    dload_next  = dload_reg;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_strobe  = '0;
    ihit        = 1'b0;
    iload       = '0;
    dhit        = 1'b0;
    dload       = '0;

    unique case (state_reg)
      IDLE: begin
        // d_done blocks re-issue so a completed store is never written twice
        if (d_req && !d_done_reg) begin
          state_next  = DATA;
          addr_next   = daddr;
          write_next  = dWEN;
          wdata_next  = dWEN ? dstore : '0;
          strobe_next = dWEN ? dstrobe : '1;
        end else if (iREN) begin
          state_next  = INSTR;
          addr_next   = iaddr;
          write_next  = 1'b0;
          wdata_next  = '0;
          strobe_next = '1;
        end
      end

      DATA: begin
        ram_ren    = !write_reg;
        ram_wen    = write_reg;
        ram_addr   = addr_reg;
        ram_wdata  = wdata_reg;
        ram_strobe = strobe_reg;
        if (ram_ready) begin
          dload_next = write_reg ? '0 : ram_rdata;
          if (iREN) begin
            state_next  = INSTR;
            addr_next   = iaddr;
            write_next  = 1'b0;
            wdata_next  = '0;
            strobe_next = '1;
            d_done_next = 1'b1;
          end else begin
            // front end halted: nobody will wait for ihit, so report data now
            state_next = IDLE;
            dhit       = d_req;
            dload      = (d_req && !write_reg) ? ram_rdata : '0;
          end
        end
      end

      INSTR: begin
        ram_ren    = 1'b1;
        ram_addr   = addr_reg;
        ram_wdata  = wdata_reg;
        ram_strobe = strobe_reg;
        if (ram_ready) begin
          state_next = IDLE;
          // a redirected or withdrawn fetch is dropped; d_done survives so
          // the pending data result is delivered with the refetch
          if (fetch_ok) begin
            ihit        = 1'b1;
            iload       = ram_rdata;
            dhit        = d_done_reg && d_req;
            dload       = (d_done_reg && d_req) ? dload_reg : '0;
            d_done_next = 1'b0;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    if (!d_req) begin
      d_done_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: RAM model with programmable wait
// states, vector table with scoreboard, plus hand-written corner sequences.
module tb_memory_arbiter;
  import common_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  word_t       iaddr;
  logic        ihit;
  word_t       iload;
  logic        dREN;
  logic        dWEN;
  word_t       daddr;
  word_t       dstore;
  logic [3:0]  dstrobe;
  logic        dhit;
  word_t       dload;
  logic        ram_ren;
  logic        ram_wen;
  word_t       ram_addr;
  word_t       ram_wdata;
  logic [3:0]  ram_strobe;
  word_t       ram_rdata;
  logic        ram_ready;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dstrobe(dstrobe),
    .dhit(dhit), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_strobe(ram_strobe),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: word array, contents 0x5A000000|index except two seeded words
  word_t mem [0:4095];
  bit    mem_loaded;
  int    wait_states;
  int    wcnt;
  int    wr_count;

  assign ram_ready = (ram_ren || ram_wen) && (wcnt >= wait_states);
  assign ram_rdata = mem[ram_addr[13:2]];

  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) begin
        if (i == 'h40)       mem[i] <= 32'h00A0_0093;
        else if (i == 'h800) mem[i] <= 32'hDEAD_BEEF;
        else                 mem[i] <= 32'h5A00_0000 | i;
      end
      mem_loaded <= 1'b1;
    end
    if (!(ram_ren || ram_wen) || ram_ready) wcnt <= 0;
    else                                    wcnt <= wcnt + 1;
    if (ram_wen && ram_ready) begin
      for (int b = 0; b < 4; b++)
        if (ram_strobe[b]) mem[ram_addr[13:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      wr_count <= wr_count + 1;
    end
  end

  logic [135:0] outs;
  assign outs = {ram_ren, ram_wen, ihit, dhit, ram_addr, ram_wdata, ram_strobe, iload, dload};

  typedef struct {
    bit         iren;
    word_t      iaddr;
    bit         dren;
    bit         dwen;
    word_t      daddr;
    word_t      dstore;
    logic [3:0] dstrobe;
    int         waits;
    bit         exp_ihit;
    bit         exp_dhit;
    word_t      exp_iload;
    word_t      exp_dload;
  } vec_t;

  typedef struct {
    bit    ihit;
    bit    dhit;
    bit    dwr;
    word_t iload;
    word_t dload;
  } exp_t;

  vec_t vecs [9];
  exp_t exp_q [$];
  int   passed;
  int   total;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic score_hit(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_hit"}, {ihit, dhit}, 2'b00);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_ihit"}, ihit, e.ihit);
    chk({tag, "_dhit"}, dhit, e.dhit);
    chk({tag, "_iload"}, iload, e.ihit ? e.iload : 32'h0);
    if (!(e.dhit && e.dwr)) chk({tag, "_dload"}, dload, e.dhit ? e.dload : 32'h0);
  endtask

  task automatic wait_hit(input string tag, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge CLK);
      if (ihit || dhit) begin
        seen = 1'b1;
        score_hit(tag);
      end
    end
    chk({tag, "_hit_in_time"}, seen, 1'b1);
  endtask

  task automatic drop_all();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t  v = vecs[idx];
    int    start_wr = wr_count;
    string tag = $sformatf("v%0d", idx);
    wait_states = v.waits;
    exp_q.push_back('{v.exp_ihit, v.exp_dhit, v.dwen, v.exp_iload, v.exp_dload});
    iREN = v.iren; iaddr = v.iaddr;
    dREN = v.dren; dWEN = v.dwen; daddr = v.daddr; dstore = v.dstore; dstrobe = v.dstrobe;
    wait_hit(tag, 60);
    drop_all();
    @(negedge CLK);
    chk({tag, "_idle_after"}, {ihit, dhit, ram_ren, ram_wen}, 4'b0000);
    if (v.dwen) chk({tag, "_one_write"}, wr_count - start_wr, 1);
    $display("vec %0d: iren=%0d iaddr=%h dren=%0d dwen=%0d daddr=%h waits=%0d", idx, v.iren, v.iaddr, v.dren, v.dwen, v.daddr, v.waits);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_wr;
    int wen_cycles;
    bit seen;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        4'b0000, 0, 1'b1, 1'b0, 32'h00A00093, 32'h0};
    vecs[1] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0,        4'b0000, 0, 1'b1, 1'b1, 32'h5A000041, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h108, 1'b0, 1'b1, 32'h2004, 32'h12345678, 4'b0011, 3, 1'b1, 1'b1, 32'h5A000042, 32'h0};
    vecs[3] = '{1'b1, 32'h10C, 1'b1, 1'b0, 32'h2004, 32'h0,        4'b0000, 1, 1'b1, 1'b1, 32'h5A000043, 32'h5A005678};
    vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h2000, 32'h0,        4'b0000, 2, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b1, 32'h110, 1'b0, 1'b1, 32'h2004, 32'hAABBCCDD, 4'b1100, 0, 1'b1, 1'b1, 32'h5A000044, 32'h0};
    vecs[6] = '{1'b1, 32'h114, 1'b1, 1'b0, 32'h2004, 32'h0,        4'b0000, 2, 1'b1, 1'b1, 32'h5A000045, 32'hAABB5678};
    vecs[7] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h2008, 32'hCAFEF00D, 4'b1111, 1, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[8] = '{1'b1, 32'h118, 1'b1, 1'b0, 32'h2008, 32'h0,        4'b0000, 1, 1'b1, 1'b1, 32'h5A000046, 32'hCAFEF00D};

    passed = 0; total = 0;
    nRST = 1'b0; wait_states = 0;
    iaddr = '0; daddr = '0; dstore = '0; dstrobe = '0;
    drop_all();

    // reset state
    repeat (3) @(negedge CLK);
    chk("reset_outputs", outs, '0);
    nRST = 1'b1;
    @(negedge CLK);
    chk("idle_outputs", outs, '0);
    $display("reset: outputs=%h", outs);

    // fetch only, zero wait states, cycle accurate
    iREN = 1'b1; iaddr = 32'h100;
    chk("fetch_c0_ren", ram_ren, 1'b0);
    @(negedge CLK);
    chk("fetch_c1_ram", {ram_ren, ram_addr, ram_strobe}, {1'b1, 32'h100, 4'hF});
    chk("fetch_c1_hit", {ihit, iload, dhit}, {1'b1, 32'h00A00093, 1'b0});
    iREN = 1'b0;
    @(negedge CLK);
    chk("fetch_c2_ihit", ihit, 1'b0);
    $display("fetch 0x100: single-cycle ihit sequence done");

    for (int i = 0; i < 9; i++) run_vec(i);

    // store with 3 wait states: held strobe, latched operands, one write
    wait_states = 3;
    start_wr = wr_count;
    wen_cycles = 0;
    seen = 1'b0;
    exp_q.push_back('{1'b1, 1'b1, 1'b1, 32'h5A000047, 32'h0});
    iREN = 1'b1; iaddr = 32'h11C;
    dWEN = 1'b1; daddr = 32'h200C; dstore = 32'h12345678; dstrobe = 4'b0011;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge CLK);
      if (ram_wen) begin
        wen_cycles++;
        chk("st_hold", {ram_addr, ram_wdata, ram_strobe}, {32'h200C, 32'h12345678, 4'b0011});
      end
      if (ihit || dhit) begin
        seen = 1'b1;
        score_hit("st3");
      end
      if (c == 0) begin
        daddr = 32'h3000; dstore = 32'hFFFF_FFFF; dstrobe = 4'b1111;
      end
    end
    chk("st3_hit_in_time", seen, 1'b1);
    drop_all();
    @(negedge CLK);
    chk("st3_wen_cycles", wen_cycles, 4);
    chk("st3_one_write", wr_count - start_wr, 1);
    chk("st3_mem", mem[12'h803], 32'h5A005678);
    $display("store 0x200C waits=3: wen_cycles=%0d writes=%0d", wen_cycles, wr_count - start_wr);

    // redirect mid-fetch: stale 0x108 dropped, 0x400 refetched
    wait_states = 2;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h5A000100, 32'h0});
    iREN = 1'b1; iaddr = 32'h108;
    @(negedge CLK);
    chk("redir_first_addr", {ram_ren, ram_addr}, {1'b1, 32'h108});
    iaddr = 32'h400;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge CLK);
      if (ihit || dhit) begin
        seen = 1'b1;
        chk("redir_hit_addr", ram_addr, 32'h400);
        score_hit("redir");
      end
    end
    chk("redir_hit_in_time", seen, 1'b1);
    drop_all();
    @(negedge CLK);
    $display("redirect 0x108->0x400: done");

    // asynchronous reset during DATA wait states
    wait_states = 5;
    dREN = 1'b1; daddr = 32'h2000; iREN = 1'b1; iaddr = 32'h100;
    @(negedge CLK);
    chk("rst_mid_data", {ram_ren, ram_addr}, {1'b1, 32'h2000});
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1 chk("rst_async_outputs", outs, '0);
    @(negedge CLK);
    chk("rst_held_outputs", outs, '0);
    nRST = 1'b1;
    wait_states = 1;
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'h00A00093, 32'hDEADBEEF});
    @(negedge CLK);
    chk("rst_restart_data", {ram_ren, ram_wen, ram_addr}, {1'b1, 1'b0, 32'h2000});
    wait_hit("rst", 30);
    drop_all();
    @(negedge CLK);
    chk("rst_idle_after", {ihit, dhit, ram_ren, ram_wen}, 4'b0000);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("reset mid-DATA: restart done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
